// File: rtl/vga_frame_capture.sv
// VGA receive path: locks onto an incoming 640x480@60 stream and writes a 4:1 decimated RGB332 frame.
// Optional CAPTURE_CHECKSUM_EN adds a per-frame 16-bit sum of written pixels on frame_sum.
module vga_frame_capture #(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] pixel_rgb,
   output logic        wr_en,
   output logic [14:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        locked,
   output logic        frame_done,
   output logic [9:0]  h_total,
   output logic [9:0]  v_total,
   output logic [15:0] frame_sum
);

   localparam logic [9:0]  H_OFF      = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  H_END      = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_OFF      = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_END      = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [9:0]  H_TOT      = 10'(H_TOTAL);
   localparam logic [9:0]  V_TOT      = 10'(V_TOTAL);
   localparam logic [14:0] LINE_WORDS = 15'(H_ACTIVE / 4);
   localparam logic [9:0]  CNT_MAX    = 10'd1023;

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] MEASURE = 2'd1;
   localparam logic [1:0] LOCKED  = 2'd2;

   logic        hs1_q, vs1_q, hs2_q, vs2_q;
   logic [7:0]  pix1_q, pix2_q;
   logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, vcnt_inc;
   logic [9:0]  h_total_q, h_total_d, v_total_q, v_total_d, h_meas;
   logic [1:0]  state_q, state_d;
   logic        h_bad_q, h_bad_d, full_q, full_d;
   logic        wr_en_q, wr_en_d, locked_q, locked_d, frame_done_q, frame_done_d;
   logic [14:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        hfall, vfall, h_err, v_err, stay_locked, in_win;
   logic [9:0]  x, y;
   logic        unused_rgb_bits;

   // Only the RGB332 bits survive past the input register.
   assign unused_rgb_bits = ^{pixel_rgb[8], pixel_rgb[4], pixel_rgb[1:0]};

   assign hfall = hs2_q & ~hs1_q;
   assign vfall = vs2_q & ~vs1_q;

   always_comb begin
      hcnt_d    = hfall ? 10'd0 : ((hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + 10'd1);
      h_meas    = hcnt_q + 10'd1;
      h_total_d = hfall ? h_meas : h_total_q;
      vcnt_inc  = (hfall && vcnt_q != CNT_MAX) ? vcnt_q + 10'd1 : vcnt_q;
      vcnt_d    = vfall ? 10'd0 : vcnt_inc;
      // A coincident hsync fall is counted before the frame length is latched.
      v_total_d = vfall ? vcnt_inc : v_total_q;
      h_err     = hfall && (h_meas != H_TOT);
      v_err     = vfall && (v_total_d != V_TOT);
      h_bad_d   = vfall ? 1'b0 : (h_bad_q | h_err);

      state_d = state_q;
      case (state_q)
         SEARCH:  if (vfall) state_d = MEASURE;
         MEASURE: if (vfall && !v_err && !h_bad_q && !h_err) state_d = LOCKED;
         LOCKED:  if (h_err || v_err || hcnt_q == CNT_MAX) state_d = SEARCH;
         default: state_d = SEARCH;
      endcase

      stay_locked  = (state_q == LOCKED) && (state_d == LOCKED);
      locked_d     = (state_d == LOCKED);
      // full_q: the current frame began in lock and has not lost it since.
      full_d       = vfall ? (state_d == LOCKED) : (full_q && state_d == LOCKED);
      frame_done_d = vfall && stay_locked && full_q;

      x      = hcnt_q - H_OFF;
      y      = vcnt_q - V_OFF;
      in_win = (hcnt_q >= H_OFF) && (hcnt_q < H_END) && (vcnt_q >= V_OFF) && (vcnt_q < V_END);

      wr_en_d   = stay_locked && in_win && (x[1:0] == 2'd0) && (y[1:0] == 2'd0);
      wr_addr_d = wr_en_d ? ({7'd0, y[9:2]} * LINE_WORDS + {7'd0, x[9:2]}) : wr_addr_q;
      wr_data_d = wr_en_d ? pix2_q : wr_data_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hs1_q        <= 1'b0;
         vs1_q        <= 1'b0;
         hs2_q        <= 1'b0;
         vs2_q        <= 1'b0;
         pix1_q       <= 8'd0;
         pix2_q       <= 8'd0;
         hcnt_q       <= 10'd0;
         vcnt_q       <= 10'd0;
         h_total_q    <= 10'd0;
         v_total_q    <= 10'd0;
         state_q      <= SEARCH;
         h_bad_q      <= 1'b0;
         full_q       <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= 15'd0;
         wr_data_q    <= 8'd0;
         locked_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         hs1_q        <= hsync;
         vs1_q        <= vsync;
         hs2_q        <= hs1_q;
         vs2_q        <= vs1_q;
         pix1_q       <= {pixel_rgb[11:9], pixel_rgb[7:5], pixel_rgb[3:2]};
         pix2_q       <= pix1_q;
         hcnt_q       <= hcnt_d;
         vcnt_q       <= vcnt_d;
         h_total_q    <= h_total_d;
         v_total_q    <= v_total_d;
         state_q      <= state_d;
         h_bad_q      <= h_bad_d;
         full_q       <= full_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         locked_q     <= locked_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef CAPTURE_CHECKSUM_EN
   logic [15:0] acc_q, acc_d, frame_sum_q, frame_sum_d;

   always_comb begin
      acc_d = acc_q;
      if (wr_en_q) acc_d = acc_q + {8'd0, wr_data_q};
      if (vfall || state_d != LOCKED) acc_d = 16'd0;
      frame_sum_d = frame_done_d ? acc_q : frame_sum_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q       <= 16'd0;
         frame_sum_q <= 16'd0;
      end else begin
         acc_q       <= acc_d;
         frame_sum_q <= frame_sum_d;
      end
   end

   assign frame_sum = frame_sum_q;
`else
   assign frame_sum = 16'd0;
`endif

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign locked     = locked_q;
   assign frame_done = frame_done_q;
   assign h_total    = h_total_q;
   assign v_total    = v_total_q;

endmodule
